// File: rtl/coeff_table_writer.sv
// Coefficient table loader: accepts a burst of DEPTH signed words, scales each
// by an arithmetic right shift, and exposes the table on a combinational read port.
module coeff_table_writer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int SHIFT  = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_in_valid,
  input  logic signed [WIDTH-1:0] i_in_data,
  output logic                    o_in_ready,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  output logic signed [WIDTH-1:0] o_rd_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [ADDR_W:0]         o_wr_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_W-1:0]       r_wr_ptr;
  logic [ADDR_W:0]         r_wr_count;
  logic signed [WIDTH-1:0] r_table [DEPTH];
  logic                    w_accept;
  logic                    w_last;
  logic                    w_rd_in_range;
  logic [IDX_W-1:0]        w_wr_idx;
  logic [IDX_W-1:0]        w_rd_idx;

  // Sign-preserving scale; >>> on a signed operand rounds toward minus infinity.
  function automatic logic signed [WIDTH-1:0] f_scale(input logic signed [WIDTH-1:0] d);
    return d >>> SHIFT;
  endfunction

  assign w_accept      = (r_state == S_LOAD) && i_in_valid;
  assign w_last        = (r_wr_ptr == LAST_PTR);
  assign w_wr_idx      = r_wr_ptr[IDX_W-1:0];
  assign w_rd_idx      = i_rd_addr[IDX_W-1:0];
  assign w_rd_in_range = ({1'b0, i_rd_addr} < DEPTH_X);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        // An abort that coincides with the final word suppresses the done pulse.
        if (w_accept && w_last) w_next_state = i_abort ? S_IDLE : S_DONE;
        else if (i_abort)       w_next_state = S_IDLE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_wr_count <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_wr_ptr   <= '0;
      r_wr_count <= '0;
    end else if (w_accept) begin
      r_wr_count <= r_wr_count + (ADDR_W + 1)'(1);
      // Pointer saturates on the last entry so it never leaves the table.
      if (!w_last) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else if (w_accept) begin
      r_table[w_wr_idx] <= f_scale(i_in_data);
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (w_rd_in_range) o_rd_data = r_table[w_rd_idx];
  end

  assign o_in_ready = (r_state == S_LOAD);
  assign o_busy     = (r_state == S_LOAD);
  assign o_done     = (r_state == S_DONE);
  assign o_wr_count = r_wr_count;

endmodule

// File: tb/tb_coeff_table_writer.sv
// Bench for coeff_table_writer: an unshifted instance and a shifted instance with
// a wider read address share one stimulus stream and are checked against a model.
module tb_coeff_table_writer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, abort, valid;
  logic signed [15:0] data;
  logic [2:0]         addr;

  logic               rdy0, busy0, done0;
  logic signed [15:0] rd0;
  logic [2:0]         cnt0;
  logic               rdy2, busy2, done2;
  logic signed [15:0] rd2;
  logic [3:0]         cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  coeff_table_writer #(.WIDTH(16), .DEPTH(4), .ADDR_W(2), .SHIFT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_in_valid(valid), .i_in_data(data), .o_in_ready(rdy0),
    .i_rd_addr(addr[1:0]), .o_rd_data(rd0), .o_busy(busy0),
    .o_done(done0), .o_wr_count(cnt0)
  );

  coeff_table_writer #(.WIDTH(16), .DEPTH(4), .ADDR_W(3), .SHIFT(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_in_valid(valid), .i_in_data(data), .o_in_ready(rdy2),
    .i_rd_addr(addr), .o_rd_data(rd2), .o_busy(busy2),
    .o_done(done2), .o_wr_count(cnt2)
  );

  // Reference model: phase 0 = idle, 1 = loading, 2 = completion cycle.
  int m_phase;
  int m_cnt;
  int m_t0 [4];
  int m_t2 [4];

  function automatic int floor4(input int d);
    int q;
    q = d / 4;
    if ((d % 4 != 0) && (d < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int exp_rd0();
    return m_t0[int'(addr[1:0])];
  endfunction

  function automatic int exp_rd2();
    return (int'(addr) < 4) ? m_t2[int'(addr)] : 0;
  endfunction

  task automatic model_clear();
    m_phase = 0;
    m_cnt   = 0;
    for (int i = 0; i < 4; i++) begin
      m_t0[i] = 0;
      m_t2[i] = 0;
    end
  endtask

  task automatic model_step();
    bit acc;
    acc = 1'b0;
    case (m_phase)
      0: if (start) begin m_phase = 1; m_cnt = 0; end
      1: begin
        acc = valid;
        if (acc) begin
          m_t0[m_cnt] = int'(data);
          m_t2[m_cnt] = floor4(int'(data));
          m_cnt++;
        end
        if (acc && (m_cnt == 4)) m_phase = abort ? 0 : 2;
        else if (abort)          m_phase = 0;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit s, input bit a, input bit v, input int d, input int ad);
    start = s;
    abort = a;
    valid = v;
    data  = 16'(d);
    addr  = 3'(ad);
  endtask

  // One clock: pre-edge read (old contents), then post-edge outputs vs model.
  task automatic cycle();
    #2;
    chk("rd0_pre", int'(rd0), exp_rd0());
    chk("rd2_pre", int'(rd2), exp_rd2());
    model_step();
    @(posedge clk);
    #1;
    chk("ready0", int'(rdy0), int'(m_phase == 1));
    chk("busy0",  int'(busy0), int'(m_phase == 1));
    chk("done0",  int'(done0), int'(m_phase == 2));
    chk("cnt0",   int'(cnt0), m_cnt);
    chk("rd0",    int'(rd0), exp_rd0());
    chk("ready2", int'(rdy2), int'(m_phase == 1));
    chk("done2",  int'(done2), int'(m_phase == 2));
    chk("cnt2",   int'(cnt2), m_cnt);
    chk("rd2",    int'(rd2), exp_rd2());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(rdy0 | rdy2), 0);
    chk({tag, "_busy"},  int'(busy0 | busy2), 0);
    chk({tag, "_done"},  int'(done0 | done2), 0);
    chk({tag, "_cnt"},   int'(cnt0) + int'(cnt2), 0);
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      #1;
      chk({tag, "_rd0"}, int'(rd0), 0);
      chk({tag, "_rd2"}, int'(rd2), 0);
    end
  endtask

  task automatic load_words(input int w0, input int w1, input int w2, input int w3);
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 0, 1, w0, 0); cycle();
    drive(0, 0, 1, w1, 1); cycle();
    drive(0, 0, 1, w2, 2); cycle();
    drive(0, 0, 1, w3, 3); cycle();
    drive(0, 0, 0, 0, 0); cycle();
  endtask

  typedef struct {
    bit s, a, v;
    int d, ad;
    int rdy, dn, cnt, rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1, 0, 0, 0,    0, 1, 0, 0, 0};
    vecs[1] = '{0, 0, 1, 1229, 0, 1, 0, 1, 1229};
    vecs[2] = '{0, 0, 1, 3482, 1, 1, 0, 2, 3482};
    vecs[3] = '{1, 0, 1, 5734, 2, 1, 0, 3, 5734};
    vecs[4] = '{0, 0, 1, 7987, 3, 0, 1, 4, 7987};
    vecs[5] = '{1, 0, 0, 0,    0, 0, 0, 4, 1229};
    vecs[6] = '{0, 1, 0, 0,    1, 0, 0, 4, 3482};
    vecs[7] = '{0, 0, 0, 0,    2, 0, 0, 4, 5734};
    vecs[8] = '{0, 0, 0, 0,    3, 0, 0, 4, 7987};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_clear();
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full load with ignored start/abort, checked against literal expectations.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].s, vecs[i].a, vecs[i].v, vecs[i].d, vecs[i].ad);
      cycle();
      chk($sformatf("vec%0d_ready", i), int'(rdy0), vecs[i].rdy);
      chk($sformatf("vec%0d_done", i),  int'(done0), vecs[i].dn);
      chk($sformatf("vec%0d_cnt", i),   int'(cnt0), vecs[i].cnt);
      chk($sformatf("vec%0d_rd", i),    int'(rd0), vecs[i].rd);
    end

    // Backpressure with a stray start mid-load.
    drive(1, 0, 0, 0, 0);   cycle();
    drive(0, 0, 1, 100, 0); cycle();
    drive(0, 0, 0, 555, 1); cycle();
    drive(0, 0, 1, 200, 1); cycle();
    drive(1, 0, 0, 666, 2); cycle();
    drive(0, 0, 1, 300, 2); cycle();
    drive(0, 0, 1, 400, 3); cycle();
    chk("bp_done", int'(done0), 1);
    drive(0, 0, 0, 0, 3);   cycle();
    chk("bp_idle_ready", int'(rdy0), 0);

    // Abort together with the second accepted word.
    drive(1, 0, 0, 0, 0);    cycle();
    drive(0, 0, 1, 1229, 0); cycle();
    drive(0, 1, 1, 3482, 1); cycle();
    chk("abort_done", int'(done0), 0);
    chk("abort_cnt", int'(cnt0), 2);
    drive(0, 0, 0, 0, 2); cycle();
    chk("abort_keep2", int'(rd0), 300);
    drive(0, 0, 0, 0, 3); cycle();
    chk("abort_keep3", int'(rd0), 400);

    // Abort on the final word: no done pulse.
    drive(1, 0, 0, 0, 0);   cycle();
    drive(0, 0, 1, 11, 0);  cycle();
    drive(0, 0, 1, 22, 1);  cycle();
    drive(0, 0, 1, 33, 2);  cycle();
    drive(0, 1, 1, -44, 3); cycle();
    chk("abort_last_done", int'(done0), 0);
    chk("abort_last_cnt", int'(cnt0), 4);
    drive(0, 0, 0, 0, 0);   cycle();

    // Shift behaviour on the shifted instance, plus an out-of-range read.
    drive(1, 0, 0, 0, 0);  cycle();
    drive(0, 0, 1, -5, 0); cycle();
    drive(0, 0, 1, 7, 0);  cycle();
    drive(0, 1, 0, 0, 0);  cycle();
    chk("shift_neg", int'(rd2), -2);
    drive(0, 0, 0, 0, 1);  cycle();
    chk("shift_pos", int'(rd2), 1);
    drive(0, 0, 0, 0, 5);  cycle();
    chk("oob_rd", int'(rd2), 0);

    // Reset in the middle of a load, then a clean full load.
    drive(1, 0, 0, 0, 0);  cycle();
    drive(0, 0, 1, 71, 0); cycle();
    drive(0, 0, 1, 72, 1); cycle();
    drive(0, 0, 1, 73, 2); cycle();
    drive(0, 0, 1, 74, 3);
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    chk("midrst_done_edge", int'(done0 | done2), 0);
    rst_n = 1'b1;
    load_words(1229, 3482, 5734, 7987);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1, int'($urandom), int'($urandom_range(0, 7)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coeff_table_writer.md
COEFF_TABLE_WRITER -- requirements
Module: coeff_table_writer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the bit width of each signed fixed-point table entry.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of table entries (2..256).
REQ-003 The block SHALL have parameter ADDR_W, default 2, giving the address width; ADDR_W >= clog2(DEPTH).
REQ-004 The block SHALL have parameter SHIFT, default 0, giving the arithmetic right shift applied to each input word before storage.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 start  input  1  request to begin a load; sampled only in IDLE.
REQ-008 abort  input  1  request to terminate a load; sampled only in LOAD.
REQ-009 in_valid  input  1  in_data is valid this cycle.
REQ-010 in_data  input  WIDTH  signed fixed-point coefficient to store.
REQ-011 in_ready  output  1  the block accepts in_data this cycle.
REQ-012 rd_addr  input  ADDR_W  table read address.
REQ-013 rd_data  output  WIDTH  combinational table contents at rd_addr.
REQ-014 busy  output  1  high while in LOAD.
REQ-015 done  output  1  one-cycle pulse on load completion.
REQ-016 wr_count  output  ADDR_W+1  number of entries written in the current or last load.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, LOAD, DONE.
REQ-018 IDLE with start=1 SHALL go to LOAD next cycle and clear the write pointer and wr_count to 0.
REQ-019 An input word SHALL be accepted only when in_valid=1 and in_ready=1 in the same cycle.
REQ-020 in_ready SHALL be 1 in LOAD and 0 in IDLE and DONE, driven from registered state only, not from in_valid.
REQ-021 An accepted word SHALL write in_data >>> SHIFT (sign-extended, truncated toward minus infinity) to table[wr_ptr], then increment wr_ptr and wr_count.
REQ-022 Accepting a word at wr_ptr = DEPTH-1 SHALL move the FSM to DONE and leave wr_count = DEPTH; wr_ptr SHALL never address beyond DEPTH-1.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 In LOAD, abort=1 SHALL move the FSM to IDLE without asserting done; entries already written and wr_count SHALL be retained.
REQ-025 abort and an accepted word in the same cycle SHALL write the word, increment wr_count, then go to IDLE; abort on the final word SHALL go to IDLE with no done.
REQ-026 start SHALL be ignored outside IDLE, and abort SHALL be ignored outside LOAD.
REQ-027 rd_data SHALL equal table[rd_addr] combinationally; a write becomes visible the cycle after acceptance, so a same-cycle read returns the old value.
REQ-028 rd_addr >= DEPTH SHALL return rd_data = 0.
REQ-029 Table entries not overwritten by a new load SHALL keep their previous values.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, clear all table entries, wr_ptr and wr_count to 0, and drive in_ready=0, busy=0 and done=0.
REQ-031 Reset asserted mid-LOAD SHALL discard the load, with no done pulse, and the table SHALL read all zeros.
REQ-032 After rst releases, the first start SHALL be recognised on the first rising edge where rst=1.

Verification
REQ-033 Full load: WIDTH=16, SHIFT=0, start, then 1229, 3482, 5734, 7987 with in_valid held -> done pulses one cycle after the 4th accept, wr_count=4, rd_addr 0..3 reads 1229/3482/5734/7987.
REQ-034 Backpressure: in_valid toggled 1,0,1,0,1,1 -> exactly 4 words written in order, done only after the 4th, in_ready=0 in DONE and IDLE.
REQ-035 Abort: abort together with the 2nd accepted word (3482) -> IDLE, no done, wr_count=2, entries 2..3 keep their prior values.
REQ-036 Shift: SHIFT=2, inputs -5 and 7 -> stored values -2 and 1.
REQ-037 Reset mid-load after 3 words -> all rd_data = 0, wr_count=0, done never asserted; a following full load succeeds.
REQ-038 Ignored controls: start during LOAD and DONE, abort in IDLE -> no state change; read-during-write returns the old value for one cycle.
